dsp_pixfifo: RTL and testbench

Receives 64-bit words from the SD reader (`WR`/`DATA`) and buffers them in a small word FIFO. It unpacks each word into sixteen 4-bit pixels and delivers one pixel per request to the display timing generator inside the display pipeline. It sits between the SD reader and the VGA scan logic, absorbing the bursty SD read rate against the steady pixel rate. It reports back-pressure and sticky error flags.

---
 rtl/dsp_pixfifo.sv | 158 +++++++++++++++
 tb/tb_dsp_pixfifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pixfifo.sv
// dsp_pixfifo: 64-bit word FIFO feeding a nibble unpacker that hands one
// 3-bit RGB pixel per request to the display timing generator.
module dsp_pixfifo #(
  parameter int unsigned AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [63:0]   i_data,
  output logic          o_full,
  output logic [AW:0]   o_level,
  input  logic          i_px_rd,
  output logic          o_px_valid,
  output logic          o_px_r,
  output logic          o_px_g,
  output logic          o_px_b,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_full;

  logic [63:0]   r_word;
  logic          r_uvalid;
  logic [3:0]    r_idx;

  logic          r_px_valid;
  logic [2:0]    r_rgb;
  logic          r_ovf;
  logic          r_unf;

  logic          w_push;
  logic          w_drop;
  logic          w_served;
  logic          w_last;
  logic          w_have;
  logic          w_pop;
  logic [AW:0]   w_level_nxt;
  logic [63:0]   w_word_sh;
  logic [3:0]    w_nibble;

  // Handshake decode: writes are refused while full, even if a pop frees a slot.
  always_comb begin
    w_push   = i_wr & ~r_full;
    w_drop   = i_wr & r_full;
    w_served = i_px_rd & r_uvalid;
    w_last   = w_served & (r_idx == 4'hF);
    w_have   = (r_level != '0);
    w_pop    = (~r_uvalid | w_last) & w_have;
  end

  // MSB-first nibble select: index k picks word bits [63-4k -: 4].
  always_comb begin
    w_word_sh = r_word << {r_idx, 2'b00};
    w_nibble  = w_word_sh[63:60];
  end

  // Occupancy after this edge.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Word storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
    end
  end

  // Unpack register: reloads on idle or on the last nibble, so no bubble at word edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word   <= '0;
      r_uvalid <= 1'b0;
      r_idx    <= '0;
    end else if (w_pop) begin
      r_word   <= r_mem[r_rptr];
      r_uvalid <= 1'b1;
      r_idx    <= '0;
    end else if (w_served) begin
      r_idx <= r_idx + 4'd1;
      if (w_last) begin
        r_uvalid <= 1'b0;
      end
    end
  end

  // Pixel output stage: served -> nibble, unserved -> black, no request -> hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_px_valid <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_px_valid <= w_served;
      if (w_served) begin
        r_rgb <= w_nibble[2:0];
      end else if (i_px_rd) begin
        r_rgb <= '0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (i_px_rd & ~r_uvalid) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign o_full     = r_full;
  assign o_level    = r_level;
  assign o_px_valid = r_px_valid;
  assign o_px_r     = r_rgb[2];
  assign o_px_g     = r_rgb[1];
  assign o_px_b     = r_rgb[0];
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;

endmodule

// File: tb/tb_dsp_pixfifo.sv
// Directed bench for dsp_pixfifo: single word, word-boundary streaming,
// overflow, underflow, push at full with pop, and reset mid-stream.
module tb_dsp_pixfifo;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          wr;
  logic [63:0]   data;
  logic          full;
  logic [AW:0]   level;
  logic          px_rd;
  logic          px_valid;
  logic          px_r;
  logic          px_g;
  logic          px_b;
  logic          ovf;
  logic          unf;

  int n_chk;
  int n_pass;

  logic [63:0] exp_q [$];

  dsp_pixfifo #(.AW(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr       (wr),
    .i_data     (data),
    .o_full     (full),
    .o_level    (level),
    .i_px_rd    (px_rd),
    .o_px_valid (px_valid),
    .o_px_r     (px_r),
    .o_px_g     (px_g),
    .o_px_b     (px_b),
    .o_ovf      (ovf),
    .o_unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check.
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr = 1'b0;
    px_rd = 1'b0;
    data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected RGB for nibble k (MSB-first) of word w: low 3 bits of the nibble.
  function automatic logic [2:0] pix(input logic [63:0] w, input int k);
    logic [63:0] s;
    s = w << (4 * k);
    return s[62:60];
  endfunction

  function automatic logic [63:0] word_k(input int k);
    logic [3:0] k4;
    k4 = 4'(k);
    return 64'h0123_4567_89AB_CDEF ^ {16{k4}};
  endfunction

  function automatic logic [2:0] rgb();
    return {px_r, px_g, px_b};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(px_valid), 64'd0);
    chk({tag, "_rgb"},   64'(rgb()),    64'd0);
    chk({tag, "_level"}, 64'(level),    64'd0);
    chk({tag, "_full"},  64'(full),     64'd0);
    chk({tag, "_ovf"},   64'(ovf),      64'd0);
    chk({tag, "_unf"},   64'(unf),      64'd0);
  endtask

  logic [63:0] w;
  logic [63:0] wa [3];

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    wr = 1'b0;
    px_rd = 1'b0;
    data = '0;

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Underflow straight out of reset
    px_rd = 1'b1;
    tick();
    px_rd = 1'b0;
    chk("unf_valid", 64'(px_valid), 64'd0);
    chk("unf_rgb",   64'(rgb()),    64'd0);
    chk("unf_flag",  64'(unf),      64'd1);
    tick();
    tick();
    chk("unf_sticky", 64'(unf), 64'd1);

    // Single word, nibbles 0..F give RGB 0..7,0..7
    do_reset();
    w = 64'h0123_4567_89AB_CDEF;
    wr = 1'b1;
    data = w;
    tick();
    wr = 1'b0;
    chk("sw_level1", 64'(level), 64'd1);
    tick();
    chk("sw_level0", 64'(level), 64'd0);
    px_rd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("sw_valid", 64'(px_valid), 64'd1);
      chk("sw_rgb",   64'(rgb()),    64'(k % 8));
    end
    tick();
    px_rd = 1'b0;
    chk("sw_17_valid", 64'(px_valid), 64'd0);
    chk("sw_17_rgb",   64'(rgb()),    64'd0);
    chk("sw_17_unf",   64'(unf),      64'd1);

    // Three words, continuous reads across both word boundaries
    do_reset();
    wa[0] = 64'hFEDC_BA98_7654_3210;
    wa[1] = 64'h1357_9BDF_0246_8ACE;
    wa[2] = 64'h7777_0000_5A5A_A5A5;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      data = wa[i];
      tick();
    end
    wr = 1'b0;
    chk("nb_level_pre", 64'(level), 64'd2);
    px_rd = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      tick();
      chk("nb_valid", 64'(px_valid), 64'd1);
      chk("nb_rgb",   64'(rgb()),    64'(pix(wa[(i - 1) / 16], (i - 1) % 16)));
      chk("nb_level", 64'(level),    (i < 16) ? 64'd2 : (i < 32) ? 64'd1 : 64'd0);
    end
    px_rd = 1'b0;
    chk("nb_unf", 64'(unf), 64'd0);

    // Overflow: 18 back-to-back writes, the 18th lands while full
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 18; k++) begin
      wr = 1'b1;
      data = word_k(k);
      if (k < 17) exp_q.push_back(word_k(k));
      tick();
      if (k == 15) chk("ovf_full15", 64'(full), 64'd0);
      if (k == 16) begin
        chk("ovf_full16",  64'(full),  64'd1);
        chk("ovf_level16", 64'(level), 64'd16);
        chk("ovf_pre",     64'(ovf),   64'd0);
      end
    end
    wr = 1'b0;
    chk("ovf_flag",  64'(ovf),   64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_full",  64'(full),  64'd1);
    px_rd = 1'b1;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      for (int k = 0; k < 16; k++) begin
        tick();
        chk("ovf_rd_valid", 64'(px_valid), 64'd1);
        chk("ovf_rd_rgb",   64'(rgb()),    64'(pix(w, k)));
      end
    end
    tick();
    px_rd = 1'b0;
    chk("ovf_end_valid", 64'(px_valid), 64'd0);
    chk("ovf_end_unf",   64'(unf),      64'd1);

    // Push while full in the same cycle as the reload pop
    do_reset();
    for (int k = 0; k < 17; k++) begin
      wr = 1'b1;
      data = word_k(k);
      tick();
    end
    wr = 1'b0;
    chk("pp_level16", 64'(level), 64'd16);
    px_rd = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    wr = 1'b1;
    data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    wr = 1'b0;
    chk("pp_valid", 64'(px_valid), 64'd1);
    chk("pp_rgb",   64'(rgb()),    64'(pix(word_k(0), 15)));
    chk("pp_level", 64'(level),    64'd15);
    chk("pp_ovf",   64'(ovf),      64'd1);
    chk("pp_full",  64'(full),     64'd0);
    tick();
    px_rd = 1'b0;
    chk("pp_next_rgb", 64'(rgb()), 64'(pix(word_k(1), 0)));

    // Reset mid-stream: discard buffered data, no stale pixels afterwards
    do_reset();
    wa[0] = 64'h89AB_CDEF_0123_4567;
    wa[1] = 64'h2222_3333_4444_5555;
    for (int i = 0; i < 2; i++) begin
      wr = 1'b1;
      data = wa[i];
      tick();
    end
    wr = 1'b0;
    px_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rm_rgb", 64'(rgb()), 64'(pix(wa[0], k)));
    end
    px_rd = 1'b0;
    tick();
    chk("rm_hold_valid", 64'(px_valid), 64'd0);
    chk("rm_hold_rgb",   64'(rgb()),    64'(pix(wa[0], 4)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rm_reset");
    px_rd = 1'b1;
    tick();
    chk("rm_unf",   64'(unf),      64'd1);
    chk("rm_valid", 64'(px_valid), 64'd0);
    chk("rm_rgb0",  64'(rgb()),    64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rm_stale", 64'(px_valid), 64'd0);
    end
    px_rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
